// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master arbiter slice.
// State encoding matches the companion APB memory slave.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_NUM_REQ = 4;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_NUM_REQ);

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after last_grant.
// The last_grant register lives in the instantiating block.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    int unsigned      idx;
    logic [IDX_W-1:0] idx_n;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_n     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx   = (32'(last_grant) + i) % NUM_REQ;
            idx_n = IDX_W'(idx);
            if (!any_valid && valid[idx_n]) begin
                any_valid    = 1'b1;
                grant[idx_n] = 1'b1;
                grant_idx    = idx_n;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master sharing one slave between NUM_REQ valid/ready requesters,
// with round-robin arbitration, PREADY timeout and one-cycle responses.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int unsigned      IDX_W    = idx_width(NUM_REQ);
    localparam int unsigned      CNT_W    = idx_width(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    apb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_valid  (arb_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Reset masks the grant so a request presented during reset is never accepted.
    assign req_ready = (state_q == IDLE && !PRESET) ? arb_grant : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d      = SETUP;
                    last_grant_d = arb_idx;
                    wait_cnt_d   = '0;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    pwrite_d     = req_write[arb_idx];
                    paddr_d      = addr_arr[arb_idx];
                    pwdata_d     = req_write[arb_idx] ? wdata_arr[arb_idx] : '0;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                // last_grant_q still names the owner of the in-flight transfer.
                if (PREADY || wait_cnt_q == CNT_MAX) begin
                    state_d                   = IDLE;
                    psel_d                    = 1'b0;
                    penable_d                 = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = (PREADY && !pwrite_q) ? PRDATA : '0;
                    rsp_err_d                 = PREADY ? PSLVERR : 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            wait_cnt_q   <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master that shares one APB slave (e.g. the 32-word memory slave) between NUM_REQ local requesters.
- Each requester uses a valid/ready request port and gets a one-cycle response pulse.
- The block arbitrates round-robin, sequences SETUP/ACCESS phases, waits on PREADY with a timeout, and returns PRDATA/PSLVERR to the winning requester.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 32: APB address width.
- DATA_W, 32: APB data width.
- TIMEOUT, 16: max ACCESS cycles with PREADY=0 before abort (>=2).

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  per-requester 1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
- rsp_rdata  out  DATA_W  shared read data, valid with rsp_valid
- rsp_err  out  1  shared error flag, valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1  APB completion/error

Behaviour:
- Reset state: state=IDLE; PSEL=PENABLE=PWRITE=0; PADDR=PWDATA=0; req_ready=rsp_valid=0; rsp_rdata=0; rsp_err=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- All APB outputs, rsp_* and state are registered. req_ready is combinational from state, req_valid and last_grant.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, cycle T, any req_valid=1:
  - Winner g = first valid index searching last_grant+1, +2, … modulo NUM_REQ.
  - req_ready[g]=1 during T only.
  - req_write/addr/wdata[g] captured at end of T; last_grant<=g; next state SETUP.
  - No valid: stay IDLE, req_ready=0.
- SETUP (T+1): PSEL=1, PENABLE=0, PADDR/PWRITE set. PWDATA = wdata for writes, 0 for reads. Next state ACCESS unconditionally.
- ACCESS (T+2 onward):
  - PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA held stable.
  - PREADY=1: capture PRDATA (reads; writes capture 0) and PSLVERR. Next state IDLE with PSEL=PENABLE=0.
  - PREADY=0: increment wait counter (reset to 0 on SETUP entry).
  - Counter reaching TIMEOUT-1 with PREADY still 0: abort to IDLE, rsp_rdata=0, rsp_err=1.
- Response: rsp_valid[g]=1 for exactly one cycle, the first IDLE cycle after ACCESS ends.
  - Minimum latency: accept at T, rsp_valid at T+3.
  - Arbitration for the next request may occur in the same cycle as rsp_valid.
- PSLVERR is ignored unless PREADY=1. rsp_err = PSLVERR OR timeout.
- Requester contract:
  - Hold req_valid and its fields stable until req_ready.
  - A requester keeping req_valid high after req_ready issues a new request.
  - Deasserting req_valid before grant is allowed; that request is dropped, no response.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-operation (any state):
  - Next edge returns to the reset state; APB outputs drop immediately.
  - In-flight transfer gets no rsp_valid.
  - last_grant returns to NUM_REQ-1.
- Simultaneous req_valid and PRESET: reset wins; no req_ready is asserted.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, same encoding as slave);
  - default ADDR_W/DATA_W;
  - a clog2-based index width helper constant.
- One sub-module, apb_rr_arbiter:
  - inputs: valid vector, last_grant;
  - outputs: one-hot grant, grant index, any_valid;
  - purely combinational, with last_grant register owned by the top.

Test Plan:
- req_valid[0]=1, write, addr=4, wdata=32'hDEADBEEF at T -> req_ready[0] at T; PSEL=1/PENABLE=0 at T+1; PENABLE=1 at T+2; rsp_valid[0] at T+3 with rsp_err=0. Slave mem[4]=32'hDEADBEEF.
- Then requester 2 reads addr=4 -> rsp_valid[2] with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- All 4 requesters held valid from reset, each issuing 2 requests -> grant order 0,1,2,3,0,1,2,3. APB PADDR matches each granted requester; no overlapping PSEL sessions.
- Requester 1 writes addr=40 -> slave asserts PSLVERR with PREADY -> rsp_valid[1] with rsp_err=1.
- PREADY tied 0, requester 3 reads addr=0 -> PENABLE high for 16 cycles, then PSEL=0. rsp_valid[3] with rsp_err=1, rsp_rdata=0.
- PRESET=1 asserted during ACCESS -> PSEL=PENABLE=0 at next edge; no rsp_valid. After release with req 0 and 1 valid, requester 0 wins first.
